// File: rtl/alu_packet_sequencer.sv
// Packet sequencer between UART RX/TX byte streams and a 32-bit accumulator.
// Parses opcode/count/operand packets, folds operands by add or shift-add multiply, returns 4 result bytes.
//
// state | meaning
// HDR0  | idle, waiting for opcode byte
// HDR1  | reserved header byte
// HDR2  | operand count low byte
// HDR3  | operand count high byte, decides the next phase
// OPND  | collecting 4 operand bytes, LSB first
// EXEC  | folding operand into accumulator
// RESP  | returning accumulator bytes 0..3
// DRAIN | discarding the operands of an unknown opcode
module alu_packet_sequencer #(
    parameter logic [7:0] OPC_ADD  = 8'h10,
    parameter logic [7:0] OPC_MUL  = 8'h11,
    parameter int         MUL_BITS = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       bad_opcode_o
);
    localparam int MCW = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

    typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, OPND, EXEC, RESP, DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_opcode;
    logic [7:0]      r_n_lo;
    logic [15:0]     r_cnt;
    logic [17:0]     r_drain;
    logic [31:0]     r_acc;
    logic [31:0]     r_op;
    logic [31:0]     r_mcand;
    logic [MCW-1:0]  r_mul_cnt;
    logic [1:0]      r_k;
    logic            r_rx_ready;
    logic            r_tx_valid;
    logic            r_bad;

    logic            w_rx_xfer;
    logic            w_tx_xfer;
    logic            w_is_add;
    logic            w_is_mul;
    logic            w_exec_done;
    logic [15:0]     w_n;
    logic [31:0]     w_opnd;
    logic [7:0]      w_tx_byte;

    assign w_rx_xfer   = r_rx_ready & rx_valid_i;
    assign w_tx_xfer   = r_tx_valid & tx_ready_i;
    assign w_is_add    = (r_opcode == OPC_ADD);
    assign w_is_mul    = (r_opcode == OPC_MUL);
    assign w_exec_done = w_is_add || (r_mul_cnt == '0);
    assign w_n         = {rx_data_i, r_n_lo};
    assign w_opnd      = {rx_data_i, r_op[31:8]};

    always_comb begin
        w_tx_byte = r_acc[7:0];
        case (r_k)
            2'd1:    w_tx_byte = r_acc[15:8];
            2'd2:    w_tx_byte = r_acc[23:16];
            2'd3:    w_tx_byte = r_acc[31:24];
            default: w_tx_byte = r_acc[7:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HDR0:  if (w_rx_xfer) w_state_nxt = HDR1;
            HDR1:  if (w_rx_xfer) w_state_nxt = HDR2;
            HDR2:  if (w_rx_xfer) w_state_nxt = HDR3;
            HDR3: begin
                if (w_rx_xfer) begin
                    if (w_is_add || w_is_mul)
                        w_state_nxt = (w_n == 16'd0) ? RESP : OPND;
                    else
                        w_state_nxt = (w_n == 16'd0) ? HDR0 : DRAIN;
                end
            end
            OPND:  if (w_rx_xfer && r_k == 2'd3) w_state_nxt = EXEC;
            EXEC:  if (w_exec_done) w_state_nxt = (r_cnt == 16'd0) ? RESP : OPND;
            RESP:  if (w_tx_xfer && r_k == 2'd3) w_state_nxt = HDR0;
            DRAIN: if (w_rx_xfer && r_drain == 18'd1) w_state_nxt = HDR0;
            default: w_state_nxt = HDR0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= HDR0;
            r_opcode   <= '0;
            r_n_lo     <= '0;
            r_cnt      <= '0;
            r_drain    <= '0;
            r_acc      <= '0;
            r_op       <= '0;
            r_mcand    <= '0;
            r_mul_cnt  <= '0;
            r_k        <= '0;
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Handshake outputs follow the next state so they are valid the cycle the state is entered.
            r_rx_ready <= (w_state_nxt inside {HDR0, HDR1, HDR2, HDR3, OPND, DRAIN});
            r_tx_valid <= (w_state_nxt == RESP);
            r_bad      <= 1'b0;
            case (r_state)
                HDR0: if (w_rx_xfer) r_opcode <= rx_data_i;
                HDR2: if (w_rx_xfer) r_n_lo <= rx_data_i;
                HDR3: begin
                    if (w_rx_xfer) begin
                        r_cnt   <= w_n;
                        r_drain <= {w_n, 2'b00};
                        r_acc   <= w_is_mul ? 32'd1 : 32'd0;
                        r_bad   <= !(w_is_add || w_is_mul);
                    end
                end
                OPND: begin
                    if (w_rx_xfer) begin
                        r_op <= w_opnd;
                        r_k  <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_cnt     <= r_cnt - 16'd1;
                            r_mcand   <= r_acc;
                            r_mul_cnt <= MCW'(MUL_BITS - 1);
                            // The accumulator becomes the partial product for the shift-add pass.
                            if (w_is_mul) r_acc <= '0;
                        end
                    end
                end
                EXEC: begin
                    if (w_is_add) begin
                        r_acc <= r_acc + r_op;
                    end else begin
                        if (r_op[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= {r_mcand[30:0], 1'b0};
                        r_op    <= {1'b0, r_op[31:1]};
                        if (r_mul_cnt != '0) r_mul_cnt <= r_mul_cnt - 1'b1;
                    end
                end
                RESP:  if (w_tx_xfer) r_k <= r_k + 2'd1;
                DRAIN: if (w_rx_xfer) r_drain <= r_drain - 18'd1;
                default: ;
            endcase
        end
    end

    assign rx_ready_o   = r_rx_ready;
    assign tx_valid_o   = r_tx_valid;
    assign tx_data_o    = r_tx_valid ? w_tx_byte : 8'h00;
    assign busy_o       = (r_state != HDR0);
    assign bad_opcode_o = r_bad;

endmodule

// File: tb/tb_alu_packet_sequencer.sv
// Directed bench for alu_packet_sequencer: packets in on RX, results and handshake timing checked on TX.
module tb_alu_packet_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       bad_opcode_o;

    alu_packet_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .busy_o       (busy_o),
        .bad_opcode_o (bad_opcode_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_rx_cyc = 0;
    int          first_v_cyc = 0;
    int          rx_acc = 0;
    int          tx_cnt = 0;
    int          bad_cnt = 0;
    logic [7:0]  tx_q[$];
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [7:0]  prev_d = 8'h00;
    logic [31:0] ops[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // TX observer: logs transfers, first-valid cycle, bad_opcode pulses and hold-while-stalled.
    always @(negedge clk_i) begin
        if (tx_valid_o && tx_ready_i) begin
            tx_q.push_back(tx_data_o);
            tx_cnt++;
        end
        if (tx_valid_o && !prev_v) first_v_cyc = cyc;
        if (prev_v && !prev_r && tx_valid_o && !rst_i) check("tx_hold", {24'h0, tx_data_o}, {24'h0, prev_d});
        if (bad_opcode_o) bad_cnt++;
        prev_v = tx_valid_o;
        prev_r = tx_ready_i;
        prev_d = tx_data_o;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        t = 0;
        while (!rx_ready_o && t < 1000) begin
            @(negedge clk_i);
            t++;
        end
        if (!rx_ready_o) begin
            check("rx_accept", {31'h0, rx_ready_o}, 32'h1);
        end else begin
            @(posedge clk_i);
            last_rx_cyc = cyc;
            rx_acc++;
        end
        #1 rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] opc, input logic [15:0] n);
        logic [31:0] v;
        send_byte(opc);
        send_byte(8'h00);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            v = ops[i];
            for (int j = 0; j < 4; j++) send_byte(v[8*j +: 8]);
        end
    endtask

    task automatic recv_word(input string tag, input logic [31:0] exp);
        int t;
        logic [31:0] w;
        t = 0;
        while (tx_q.size() < 4 && t < 2000) begin
            @(posedge clk_i);
            t++;
        end
        if (tx_q.size() < 4) begin
            check({tag, "_timeout"}, tx_q.size(), 32'd4);
        end else begin
            w = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
            repeat (4) void'(tx_q.pop_front());
            check(tag, w, exp);
        end
    endtask

    initial begin
        int base;
        int b0;
        int a0;
        int t;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_rx_ready", {31'h0, rx_ready_o}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_tx_data",  {24'h0, tx_data_o}, 32'h0);
        check("rst_busy",     {31'h0, busy_o}, 32'h0);
        check("rst_bad",      {31'h0, bad_opcode_o}, 32'h0);
        rst_i = 1'b0;

        // ADD 1+2
        ops[0] = 32'd1; ops[1] = 32'd2;
        base = tx_cnt;
        send_pkt(8'h10, 16'd2);
        recv_word("add_1_2", 32'h0000_0003);
        @(negedge clk_i);
        check("add_busy_idle", {31'h0, busy_o}, 32'h0);
        repeat (3) @(negedge clk_i);
        check("add_tx_count", tx_cnt - base, 32'd4);

        // MUL 1..5 = 120, latency from last RX byte to first TX valid
        for (int i = 0; i < 5; i++) ops[i] = 32'(i + 1);
        send_pkt(8'h11, 16'd5);
        recv_word("mul_1_5", 32'h0000_0078);
        // first_v_cyc is sampled after the edge, last_rx_cyc before it, hence the -1.
        check("mul_latency", first_v_cyc - 1 - last_rx_cyc, 32'd32);

        ops[0] = 32'h0001_0000; ops[1] = 32'h0001_0000;
        send_pkt(8'h11, 16'd2);
        recv_word("mul_wrap", 32'h0000_0000);
        ops[0] = 32'hFFFF_FFFF; ops[1] = 32'd2;
        send_pkt(8'h10, 16'd2);
        recv_word("add_wrap", 32'h0000_0001);

        // unknown opcode drains its operands silently
        ops[0] = 32'hDEAD_BEEF; ops[1] = 32'h1011_1213;
        base = tx_cnt; b0 = bad_cnt; a0 = rx_acc;
        send_pkt(8'h22, 16'd2);
        repeat (5) @(negedge clk_i);
        check("bad_rx_bytes", rx_acc - a0, 32'd12);
        check("bad_pulses",   bad_cnt - b0, 32'd1);
        check("bad_no_tx",    tx_cnt - base, 32'd0);
        check("bad_idle",     {31'h0, busy_o}, 32'h0);
        ops[0] = 32'd3; ops[1] = 32'd4;
        send_pkt(8'h10, 16'd2);
        recv_word("add_after_bad", 32'h0000_0007);

        // TX back-pressure: 20 stalled cycles per byte
        @(posedge clk_i);
        #1 tx_ready_i = 1'b0;
        ops[0] = 32'd1; ops[1] = 32'd2;
        base = tx_cnt;
        send_pkt(8'h10, 16'd2);
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!tx_valid_o && t < 200) begin
                @(negedge clk_i);
                t++;
            end
            if (!tx_valid_o) check("stall_valid", {31'h0, tx_valid_o}, 32'h1);
            repeat (20) @(posedge clk_i);
            #1 tx_ready_i = 1'b1;
            @(posedge clk_i);
            #1 tx_ready_i = 1'b0;
        end
        repeat (5) @(negedge clk_i);
        check("stall_tx_count", tx_cnt - base, 32'd4);
        check("stall_idle", {31'h0, tx_valid_o}, 32'h0);
        @(posedge clk_i);
        #1 tx_ready_i = 1'b1;
        recv_word("stall_result", 32'h0000_0003);

        // reset in the middle of an operand
        send_byte(8'h11); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h66);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("mid_rst_rx_ready", {31'h0, rx_ready_o}, 32'h0);
        check("mid_rst_busy",     {31'h0, busy_o}, 32'h0);
        check("mid_rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("mid_rst_stale", tx_q.size(), 32'd0);
        ops[0] = 32'd5; ops[1] = 32'd6;
        send_pkt(8'h11, 16'd2);
        recv_word("mul_after_rst", 32'h0000_001E);

        // zero operand count returns the identity
        send_pkt(8'h10, 16'd0);
        recv_word("add_n0", 32'h0000_0000);
        send_pkt(8'h11, 16'd0);
        recv_word("mul_n0", 32'h0000_0001);
        repeat (5) @(negedge clk_i);
        check("final_queue_empty", tx_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
